apb_arbiter: RTL and testbench

Two-port APB master arbiter that shares the single `sram` APB slave between the core's instruction-fetch port (port 0) and data load/store port (port 1). Each port issues a simple request/acknowledge transfer. The arbiter grants one port at a time with round-robin fairness and runs a full APB SETUP/ACCESS sequence for it. It returns read data and error status, and aborts hung transfers with a programmable timeout.

---
 rtl/apb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_apb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-port round-robin APB master arbiter with access timeout
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [3:0]            m0_stb,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [3:0]            m1_stb,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic [3:0]            pstb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [3:0]            pstb_q, pstb_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic                  elig0, elig1, pick;
    logic                  done, done_err;
    logic [DATA_WIDTH-1:0] done_rdata;
    logic [CNT_W-1:0]      cnt_inc;

    // A port in its ack cycle is not eligible, so the other port wins that IDLE cycle.
    assign elig0   = m0_req && !ack0_q;
    assign elig1   = m1_req && !ack1_q;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pdata_d    = pdata_q;
        pstb_d     = pstb_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        pick       = 1'b0;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    pick     = (elig0 && elig1) ? ~last_q : elig1;
                    gnt_d    = pick;
                    last_d   = pick;
                    paddr_d  = pick ? m1_addr  : m0_addr;
                    pdata_d  = pick ? m1_wdata : m0_wdata;
                    pwrite_d = pick ? m1_write : m0_write;
                    pstb_d   = pick ? m1_stb   : m0_stb;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                if (pready) begin
                    done       = 1'b1;
                    done_err   = perr;
                    done_rdata = prdata;
                end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                    done       = 1'b1;
                    done_err   = 1'b1;
                end
                if (done) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                        err1_d = done_err;
                        if (!pwrite_q) rdata1_d = done_rdata;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = done_err;
                        if (!pwrite_q) rdata0_d = done_rdata;
                    end
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pdata_q   <= '0;
            pstb_q    <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
            pstb_q    <= pstb_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pdata    = pdata_q;
    assign pstb     = pstb_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_err   = err0_q;
    assign m1_err   = err1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - directed self-checking bench for apb_arbiter
module tb_apb_arbiter;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        m0_req, m1_req, m0_write, m1_write;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_stb, m1_stb;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pdata, prdata;
    logic [3:0]  pstb;
    logic        pready, perr;

    logic [31:0] slave_rdata;
    int          slave_wait;
    logic        slave_hang, slave_err;
    int          acc_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 pclk = ~pclk;

    apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pdata(pdata),
        .pstb(pstb), .prdata(prdata), .pready(pready), .perr(perr)
    );

    // Slave with a programmable number of wait states; ready is withheld forever when hung.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn)              acc_cnt <= 0;
        else if (psel && penable)  acc_cnt <= pready ? 0 : acc_cnt + 1;
        else                       acc_cnt <= 0;
    end
    assign pready = psel && penable && !slave_hang && (acc_cnt == slave_wait);
    assign perr   = pready && slave_err;
    assign prdata = slave_rdata;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        step();
        step();
        tests_run++;
        if ({psel, penable, pwrite, paddr, pdata, pstb, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: psel=%b penable=%b paddr=%h m0_ack=%b m1_ack=%b m0_rdata=%h m1_rdata=%h, all required 0",
                     psel, penable, paddr, m0_ack, m1_ack, m0_rdata, m1_rdata);
        end
        presetn = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        slave_wait = 0; slave_rdata = 32'hDEAD_BEEF;
        m0_req = 1'b1; m0_addr = 32'h100; m0_write = 1'b0; m0_stb = 4'hF;
        step();
        tests_run++;
        if ({psel, penable, paddr} !== {1'b1, 1'b0, 32'h100}) begin
            tests_failed++;
            $display("FAIL read_setup: psel=%b penable=%b paddr=%h, required 1 0 00000100", psel, penable, paddr);
        end
        step();
        tests_run++;
        if ({psel, penable, m0_ack} !== 3'b110) begin
            tests_failed++;
            $display("FAIL read_access: psel=%b penable=%b ack=%b, required 1 1 0", psel, penable, m0_ack);
        end
        step();
        tests_run++;
        if ({m0_ack, m0_err, m0_rdata, psel} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_ack: ack=%b err=%b rdata=%h psel=%b, required 1 0 deadbeef 0", m0_ack, m0_err, m0_rdata, psel);
        end
        m0_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        slave_hang = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h300; m0_write = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        tests_run++;
        if ({m0_ack, psel, penable} !== 3'b011) begin
            tests_failed++;
            $display("FAIL timeout_early: cycle5 ack=%b psel=%b penable=%b, required 0 1 1", m0_ack, psel, penable);
        end
        step();
        tests_run++;
        if ({m0_ack, m0_err, m0_rdata, psel, penable} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_ack: ack=%b err=%b rdata=%h psel=%b, required 1 1 00000000 0", m0_ack, m0_err, m0_rdata, psel);
        end
        m0_req = 1'b0;
        slave_hang = 1'b0;
        step();
        tests_run++;
        if ({m0_ack, m0_err, psel} !== 3'b000) begin
            tests_failed++;
            $display("FAIL timeout_after: ack=%b err=%b psel=%b, required 0 0 0", m0_ack, m0_err, psel);
        end
    endtask

    task automatic test_simultaneous();
        presetn = 1'b0;
        step();
        presetn = 1'b1;
        step();
        slave_wait = 0; slave_rdata = 32'h1111_2222;
        m0_req = 1'b1; m0_addr = 32'h40; m0_write = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h80; m1_write = 1'b0;
        for (int c = 1; c <= 3; c++) step();
        tests_run++;
        if ({m0_ack, m1_ack, m0_rdata} !== {1'b1, 1'b0, 32'h1111_2222}) begin
            tests_failed++;
            $display("FAIL simul_port0_ack: m0_ack=%b m1_ack=%b m0_rdata=%h, required 1 0 11112222", m0_ack, m1_ack, m0_rdata);
        end
        m0_req = 1'b0;
        step();
        tests_run++;
        if ({psel, penable, paddr} !== {1'b1, 1'b0, 32'h80}) begin
            tests_failed++;
            $display("FAIL simul_port1_setup: psel=%b penable=%b paddr=%h, required 1 0 00000080", psel, penable, paddr);
        end
        slave_rdata = 32'h3333_4444;
        step();
        step();
        tests_run++;
        if ({m1_ack, m0_ack, m1_rdata} !== {1'b1, 1'b0, 32'h3333_4444}) begin
            tests_failed++;
            $display("FAIL simul_port1_ack: m1_ack=%b m0_ack=%b m1_rdata=%h, required 1 0 33334444", m1_ack, m0_ack, m1_rdata);
        end
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_continuous();
        int order[6];
        int n = 0;
        int cyc = 0;
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};
        slave_rdata = 32'hA5A5_0001;
        m0_req = 1'b1; m0_addr = 32'h10; m0_write = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h20; m1_write = 1'b0;
        while (n < 6 && cyc < 80) begin
            step();
            cyc++;
            if (m0_ack && m1_ack) begin
                tests_run++;
                tests_failed++;
                $display("FAIL cont_double_ack: both acks high in cycle %0d, required one", cyc);
            end
            if (m0_ack) begin order[n] = 0; n++; end
            else if (m1_ack) begin order[n] = 1; n++; end
        end
        tests_run++;
        if (n != 6) begin
            tests_failed++;
            $display("FAIL cont_ack_count: saw %0d acks in %0d cycles, required 6", n, cyc);
        end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (order[i] != exp_order[i]) begin
                tests_failed++;
                $display("FAIL cont_grant_order[%0d]: got port %0d, required port %0d", i, order[i], exp_order[i]);
            end
        end
        m1_req = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (!m0_ack && cyc < 20);
        tests_run++;
        if (!m0_ack) begin
            tests_failed++;
            $display("FAIL cont_final_ack: m0_ack=%b after %0d cycles, required 1", m0_ack, cyc);
        end
        m0_req = 1'b0;
        step();
    endtask

    task automatic test_write_wait();
        slave_wait = 2;
        m1_req = 1'b1; m1_addr = 32'h204; m1_wdata = 32'h1234_5678; m1_write = 1'b1; m1_stb = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            step();
            m1_addr = 32'hFFF; m1_wdata = 32'h0; m1_stb = 4'hF;
            tests_run++;
            if ({psel, pwrite, paddr, pdata, pstb, m1_ack} !== {1'b1, 1'b1, 32'h204, 32'h1234_5678, 4'b0011, 1'b0}) begin
                tests_failed++;
                $display("FAIL write_bus_cycle%0d: psel=%b pwrite=%b paddr=%h pdata=%h pstb=%b ack=%b, required 1 1 00000204 12345678 0011 0",
                         c, psel, pwrite, paddr, pdata, pstb, m1_ack);
            end
        end
        step();
        tests_run++;
        if ({m1_ack, m1_err, m1_rdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
            tests_failed++;
            $display("FAIL write_ack: ack=%b err=%b rdata=%h, required 1 0 a5a50001", m1_ack, m1_err, m1_rdata);
        end
        m1_req = 1'b0; m1_write = 1'b0;
        slave_wait = 0;
        step();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_addr = 32'h400; m1_write = 1'b0;
        step();
        step();
        tests_run++;
        if ({psel, penable} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rstmid_access: psel=%b penable=%b, required 1 1", psel, penable);
        end
        presetn = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h500; m0_write = 1'b0;
        #1;
        tests_run++;
        if ({psel, penable, m0_ack, m1_ack} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstmid_async_drop: psel=%b penable=%b m0_ack=%b m1_ack=%b, required 0 0 0 0", psel, penable, m0_ack, m1_ack);
        end
        step();
        presetn = 1'b1;
        step();
        tests_run++;
        if ({psel, paddr, m1_ack} !== {1'b1, 32'h500, 1'b0}) begin
            tests_failed++;
            $display("FAIL rstmid_port0_first: psel=%b paddr=%h m1_ack=%b, required 1 00000500 0", psel, paddr, m1_ack);
        end
        step();
        step();
        tests_run++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rstmid_port0_ack: m0_ack=%b m1_ack=%b, required 1 0", m0_ack, m1_ack);
        end
        m0_req = 1'b0;
        for (int c = 0; c < 3; c++) step();
        tests_run++;
        if ({m1_ack, m0_ack} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rstmid_port1_ack: m1_ack=%b m0_ack=%b, required 1 0", m1_ack, m0_ack);
        end
        m1_req = 1'b0;
        step();
    endtask

    initial begin
        presetn = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_write = 1'b0; m0_stb = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_write = 1'b0; m1_stb = '0;
        slave_rdata = '0; slave_wait = 0; slave_hang = 1'b0; slave_err = 1'b0;
        test_reset();
        test_single_read();
        test_timeout();
        test_simultaneous();
        test_continuous();
        test_write_wait();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
